hand_detect_sequencer: RTL and testbench

//  Front end of the dispenser: conditions photoresistor input pr0 and decides when to dispense.

---
 rtl/candy_pkg.sv | 26 ++
 rtl/tick_divider.sv | 30 +++
 rtl/hand_detect_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_hand_detect_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candy_pkg.sv
// Shared types and default timing for the dispenser front end and servo stage.
// Default constants match the production 50 MHz board.
package candy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    REQ,
    LOCKOUT,
    WAIT_RELEASE
  } hds_state_t;

  localparam int unsigned HDS_CLK_HZ        = 50_000_000;
  localparam int unsigned HDS_TICK_HZ       = 1_000;
  localparam int unsigned HDS_INTEG_MAX     = 1000;
  localparam int unsigned HDS_ASSERT_THR    = 750;
  localparam int unsigned HDS_DEASSERT_THR  = 250;
  localparam int unsigned HDS_HOLD_TICKS    = 200;
  localparam int unsigned HDS_LOCKOUT_TICKS = 2000;

  // width for a counter spanning 0..n-1, never below one bit
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
// Count resets to 0; tick fires while count sits at DIV-1.
module tick_divider
  import candy_pkg::*;
#(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk_50m,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = cw(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // count 0..DIV-1 and wrap on tick
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hand_detect_sequencer.sv
// Hand detector: sync, integrate, hysteresis, hold qualify, req/ack, lockout.
// Optional accepted-dispense counter: define DISPENSE_COUNT_EN.
module hand_detect_sequencer
  import candy_pkg::*;
#(
  parameter int unsigned CLK_HZ        = HDS_CLK_HZ,
  parameter int unsigned TICK_HZ       = HDS_TICK_HZ,
  parameter int unsigned INTEG_MAX     = HDS_INTEG_MAX,
  parameter int unsigned ASSERT_THR    = HDS_ASSERT_THR,
  parameter int unsigned DEASSERT_THR  = HDS_DEASSERT_THR,
  parameter int unsigned HOLD_TICKS    = HDS_HOLD_TICKS,
  parameter int unsigned LOCKOUT_TICKS = HDS_LOCKOUT_TICKS
) (
  input  logic        clk_50m,
  input  logic        rst,
  input  logic        pr0,
  output logic        dispense_req,
  input  logic        dispense_ack,
  output logic        hand_present,
  output logic        busy
`ifdef DISPENSE_COUNT_EN
  ,
  output logic [15:0] dispense_count
`endif
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned LW  = $clog2(INTEG_MAX + 1);
  localparam int unsigned HW  = cw(HOLD_TICKS);
  localparam int unsigned KW  = cw(LOCKOUT_TICKS);

  localparam logic [LW-1:0] LV_MAX = LW'(INTEG_MAX);
  localparam logic [LW-1:0] LV_SET = LW'(ASSERT_THR);
  localparam logic [LW-1:0] LV_CLR = LW'(DEASSERT_THR);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(LOCKOUT_TICKS - 1);

  logic          pr0_m;
  logic          pr0_s;
  logic          tick;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          hp_nxt;
  logic          hp_prev;
  logic          hp_rise;

  hds_state_t    state;
  hds_state_t    state_nxt;
  logic [HW-1:0] hold_ctr;
  logic [HW-1:0] hold_nxt;
  logic [KW-1:0] lock_ctr;
  logic [KW-1:0] lock_nxt;

  tick_divider #(
    .DIV (DIV)
  ) u_tick (
    .clk_50m (clk_50m),
    .rst     (rst),
    .tick    (tick)
  );

  // bring the photoresistor level into the clock domain
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      pr0_m <= 1'b0;
      pr0_s <= 1'b0;
    end else begin
      pr0_m <= pr0;
      pr0_s <= pr0_m;
    end
  end

  // saturating up/down step of the integrator
  always_comb begin
    level_nxt = level;
    if (pr0_s) begin
      if (level != LV_MAX) level_nxt = level + LW'(1);
    end else begin
      if (level != '0) level_nxt = level - LW'(1);
    end
  end

  // hysteresis judged on the level this tick produces
  always_comb begin
    hp_nxt = hand_present;
    if (level_nxt > LV_SET) begin
      hp_nxt = 1'b1;
    end else if (level_nxt < LV_CLR) begin
      hp_nxt = 1'b0;
    end
  end

  // integrator and presence flag advance only on tick
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      level        <= '0;
      hand_present <= 1'b0;
    end else if (tick) begin
      level        <= level_nxt;
      hand_present <= hp_nxt;
    end
  end

  assign hp_rise = hand_present & ~hp_prev;

  // sequencer next state and counters
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_ctr;
    lock_nxt  = lock_ctr;
    unique case (state)
      IDLE: begin
        if (hp_rise) begin
          state_nxt = QUALIFY;
          hold_nxt  = '0;
        end
      end
      QUALIFY: begin
        if (!hand_present) begin
          state_nxt = IDLE;
        end else if (tick) begin
          if (hold_ctr == H_LAST) begin
            state_nxt = REQ;
          end else begin
            hold_nxt = hold_ctr + HW'(1);
          end
        end
      end
      REQ: begin
        if (dispense_ack) begin
          state_nxt = LOCKOUT;
          lock_nxt  = '0;
        end
      end
      LOCKOUT: begin
        if (tick) begin
          if (lock_ctr == K_LAST) begin
            state_nxt = hand_present ? WAIT_RELEASE : IDLE;
          end else begin
            lock_nxt = lock_ctr + KW'(1);
          end
        end
      end
      WAIT_RELEASE: begin
        if (!hand_present) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state register; request follows the state it is entering
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state        <= IDLE;
      hold_ctr     <= '0;
      lock_ctr     <= '0;
      hp_prev      <= 1'b0;
      dispense_req <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_ctr     <= hold_nxt;
      lock_ctr     <= lock_nxt;
      hp_prev      <= hand_present;
      dispense_req <= (state_nxt == REQ);
    end
  end

  assign busy = (state != IDLE);

`ifdef DISPENSE_COUNT_EN
  logic acc;

  assign acc = (state == REQ) && dispense_ack;

  // accepted handshakes, wrapping at 16 bits
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      dispense_count <= '0;
    end else if (acc) begin
      dispense_count <= dispense_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hand_detect_sequencer.sv
// Bench for hand_detect_sequencer at a 10 kHz clock / 1 kHz tick.
// A second instance with a long hold time exercises the QUALIFY abort path.
`ifdef DISPENSE_COUNT_EN
`define EXP_CNT(v) (16'(v))
`else
`define EXP_CNT(v) (16'd0)
`endif

module tb_hand_detect_sequencer;

  logic clk_50m = 1'b0;
  always #5 clk_50m = ~clk_50m;

  logic rst, pr0, ack, pr0_b, ack_b;
  logic req, hp, busy, req_b, hp_b, busy_b;
  logic [15:0] cnt, cnt_b;

  int total = 0;
  int bad = 0;
  int model_cnt = 0;
  int rd = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic req_d = 1'b0;
  logic req_b_d = 1'b0;
  int b_rises = 0;

  hand_detect_sequencer #(
    .CLK_HZ(10_000), .TICK_HZ(1_000), .INTEG_MAX(20),
    .ASSERT_THR(15), .DEASSERT_THR(5),
    .HOLD_TICKS(4), .LOCKOUT_TICKS(10)
  ) u_dut (
    .clk_50m(clk_50m), .rst(rst), .pr0(pr0),
    .dispense_req(req), .dispense_ack(ack),
    .hand_present(hp), .busy(busy)
`ifdef DISPENSE_COUNT_EN
    , .dispense_count(cnt)
`endif
  );

  // level needs 12 ticks to fall from 16 below 5, so hold must exceed that
  hand_detect_sequencer #(
    .CLK_HZ(10_000), .TICK_HZ(1_000), .INTEG_MAX(20),
    .ASSERT_THR(15), .DEASSERT_THR(5),
    .HOLD_TICKS(16), .LOCKOUT_TICKS(10)
  ) u_dut_b (
    .clk_50m(clk_50m), .rst(rst), .pr0(pr0_b),
    .dispense_req(req_b), .dispense_ack(ack_b),
    .hand_present(hp_b), .busy(busy_b)
`ifdef DISPENSE_COUNT_EN
    , .dispense_count(cnt_b)
`endif
  );

`ifndef DISPENSE_COUNT_EN
  assign cnt = 16'd0;
  assign cnt_b = 16'd0;
`endif

  // record every request rising edge with the count it carried
  always @(negedge clk_50m) begin
    req_d <= req;
    req_b_d <= req_b;
    if (req === 1'b1 && req_d !== 1'b1) obs_q.push_back(cnt);
    if (req_b === 1'b1 && req_b_d !== 1'b1) b_rises <= b_rises + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50m);
    #1;
  endtask

  // hold pr0 high and answer each request with an ack 3 cycles later
  task automatic run_presence(input int cycles);
    int dly;
    dly = 0;
    pr0 = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      cyc(1);
      ack = 1'b0;
      if (req) begin
        if (dly == 3) begin
          ack = 1'b1;
          model_cnt++;
        end
        dly++;
      end else begin
        dly = 0;
      end
    end
    cyc(1);
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pr0 = 1'b1; ack = 1'b0; pr0_b = 1'b0; ack_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      total++;
      if ({req, hp, busy, cnt, req_b, hp_b, busy_b, cnt_b} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got req=%b hp=%b busy=%b cnt=%0d, need all 0",
                 req, hp, busy, cnt);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_dispense;
    logic busy_low, req_high, found;
    exp_q.push_back(`EXP_CNT(0));
    cyc(150);
    total++;
    if (hp !== 1'b0) begin
      bad++; $display("FAIL hp_tick15: got %b need 0", hp);
    end
    cyc(10);
    total++;
    if (hp !== 1'b1) begin
      bad++; $display("FAIL hp_tick16: got %b need 1", hp);
    end
    cyc(39);
    total++;
    if (req !== 1'b0) begin
      bad++; $display("FAIL req_early: got %b need 0", req);
    end
    cyc(1);
    total++;
    if (req !== 1'b1) begin
      bad++; $display("FAIL req_tick20: got %b need 1", req);
    end
    cyc(3);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    model_cnt = 1;
    total++;
    if (req !== 1'b0 || cnt !== `EXP_CNT(model_cnt)) begin
      bad++;
      $display("FAIL ack_accept: got req=%b cnt=%0d need req=0 cnt=%0d",
               req, cnt, `EXP_CNT(model_cnt));
    end
    busy_low = 1'b0; req_high = 1'b0;
    for (int i = 0; i < 126; i++) begin
      cyc(1);
      if (busy !== 1'b1) busy_low = 1'b1;
      if (req !== 1'b0) req_high = 1'b1;
    end
    total++;
    if (busy_low || req_high) begin
      bad++;
      $display("FAIL lockout_busy: got busy_dropped=%b req_seen=%b need 0 0",
               busy_low, req_high);
    end
    total++;
    if (obs_q.size() <= rd) begin
      bad++; $display("FAIL sb_first_req: got no request, need one");
    end else begin
      if (obs_q[rd] !== exp_q[rd]) begin
        bad++;
        $display("FAIL sb_first_req: got cnt=%0d need %0d", obs_q[rd], exp_q[rd]);
      end
      rd++;
    end
    pr0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (busy === 1'b0) found = 1'b1;
    end
    total++;
    if (!found || hp !== 1'b0) begin
      bad++;
      $display("FAIL release_idle: got idle=%b hp=%b need 1 0", found, hp);
    end
    cyc(300);
  endtask

  task automatic test_glitch;
    int n0;
    logic hp_seen, busy_seen;
    n0 = obs_q.size();
    hp_seen = 1'b0; busy_seen = 1'b0;
    pr0 = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if (i == 100) pr0 = 1'b0;
      cyc(1);
      if (hp !== 1'b0) hp_seen = 1'b1;
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    total++;
    if (hp_seen || busy_seen) begin
      bad++;
      $display("FAIL glitch_hp: got hp_seen=%b busy_seen=%b need 0 0",
               hp_seen, busy_seen);
    end
    total++;
    if (obs_q.size() != n0) begin
      bad++;
      $display("FAIL glitch_req: got %0d requests need 0", obs_q.size() - n0);
    end
  endtask

  task automatic test_one_per_presentation;
    logic found;
    for (int p = 0; p < 2; p++) begin
      exp_q.push_back(`EXP_CNT(model_cnt));
      run_presence(600);
      total++;
      if (obs_q.size() - rd != 1) begin
        bad++;
        $display("FAIL one_req_p%0d: got %0d requests need 1", p, obs_q.size() - rd);
      end
      if (obs_q.size() > rd) begin
        total++;
        if (obs_q[rd] !== exp_q[rd]) begin
          bad++;
          $display("FAIL sb_req_p%0d: got cnt=%0d need %0d", p, obs_q[rd], exp_q[rd]);
        end
      end
      rd = obs_q.size();
      total++;
      if (cnt !== `EXP_CNT(model_cnt)) begin
        bad++;
        $display("FAIL count_p%0d: got %0d need %0d", p, cnt, `EXP_CNT(model_cnt));
      end
      pr0 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        cyc(1);
        if (hp === 1'b0 && busy === 1'b0) found = 1'b1;
      end
      total++;
      if (!found) begin
        bad++;
        $display("FAIL release_p%0d: got hp=%b busy=%b need 0 0", p, hp, busy);
      end
    end
    cyc(300);
  endtask

  task automatic test_abort_qualify;
    logic found, rq;
    int n0;
    n0 = b_rises;
    pr0_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (hp_b === 1'b1) found = 1'b1;
    end
    pr0_b = 1'b0;
    total++;
    if (!found) begin
      bad++; $display("FAIL abort_hp: got hp=%b need 1", hp_b);
    end
    cyc(2);
    total++;
    if (busy_b !== 1'b1) begin
      bad++; $display("FAIL abort_qualify: got busy=%b need 1", busy_b);
    end
    found = 1'b0; rq = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (req_b !== 1'b0) rq = 1'b1;
      if (busy_b === 1'b0) found = 1'b1;
    end
    total++;
    if (!found || rq || hp_b !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got idle=%b req_seen=%b hp=%b need 1 0 0",
               found, rq, hp_b);
    end
    cyc(2);
    total++;
    if (b_rises != n0 || cnt_b !== 16'd0) begin
      bad++;
      $display("FAIL abort_count: got rises=%0d cnt=%0d need 0 0", b_rises - n0, cnt_b);
    end
    cyc(300);
  endtask

  task automatic test_reset_mid_request;
    logic found, rq, bz;
    exp_q.push_back(`EXP_CNT(model_cnt));
    pr0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(1);
      if (req === 1'b1) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL mid_req_wait: got req=%b need 1", req);
    end
    rst = 1'b1;
    pr0 = 1'b0;
    cyc(1);
    rst = 1'b0;
    model_cnt = 0;
    total++;
    if (req !== 1'b0 || hp !== 1'b0 || cnt !== `EXP_CNT(0)) begin
      bad++;
      $display("FAIL mid_reset: got req=%b hp=%b cnt=%0d need 0 0 0", req, hp, cnt);
    end
    total++;
    if (obs_q.size() <= rd || obs_q[rd] !== exp_q[rd]) begin
      bad++;
      $display("FAIL sb_mid_req: got %0d seen, need cnt %0d", obs_q.size() - rd, exp_q[rd]);
    end
    rd = obs_q.size();
    rq = 1'b0; bz = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ack = (i % 7 == 3);
      cyc(1);
      if (req !== 1'b0) rq = 1'b1;
      if (busy !== 1'b0) bz = 1'b1;
    end
    ack = 1'b0;
    cyc(2);
    total++;
    if (rq || bz || cnt !== `EXP_CNT(0) || obs_q.size() != rd) begin
      bad++;
      $display("FAIL idle_ack: got req_seen=%b busy_seen=%b cnt=%0d need 0 0 0",
               rq, bz, cnt);
    end
  endtask

  initial begin
    test_reset();
    test_dispense();
    test_glitch();
    test_one_per_presentation();
    test_abort_qualify();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
